// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement queue with CDB capture, commit and mispredict flush
// Optional feature macro: ROB_CDB_BYPASS_EN (forward same-cycle CDB results to operand lookups).
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueValid,
  input  logic [4:0]           issueDest,
  input  logic                 issueIsBranch,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueRedirectPc,
  output logic [ROB_WIDTH-1:0] issueRobId,
  output logic                 robFull,
  input  logic                 cdbValid,
  input  logic [ROB_WIDTH-1:0] cdbRobId,
  input  logic [31:0]          cdbValue,
  input  logic                 cdbTaken,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic [ROB_WIDTH-1:0] robRs1Dep,
  input  logic [ROB_WIDTH-1:0] robRs2Dep,
  output logic                 robRs1Ready,
  output logic                 robRs2Ready,
  output logic [31:0]          robRs1Value,
  output logic [31:0]          robRs2Value,
  output logic                 clearOut,
  output logic [31:0]          redirectPcOut
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]   FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);
  localparam logic [ROB_WIDTH:0]   CNT_ONE    = (ROB_WIDTH + 1)'(1);
  localparam logic [ROB_WIDTH-1:0] PTR_ONE    = ROB_WIDTH'(1);

  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     r_ready;
  logic [DEPTH-1:0]     r_is_branch;
  logic [DEPTH-1:0]     r_pred_taken;
  logic [DEPTH-1:0]     r_taken;
  logic [4:0]           r_dest     [DEPTH];
  logic [31:0]          r_value    [DEPTH];
  logic [31:0]          r_redirect [DEPTH];

  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  logic                 r_reg_valid;
  logic [4:0]           r_reg_dest;
  logic [31:0]          r_reg_value;
  logic [ROB_WIDTH-1:0] r_reg_rob_id;
  logic                 r_clear;
  logic [31:0]          r_redirect_pc;

  logic w_full;
  logic w_issue;
  logic w_commit;
  logic w_mispredict;
  logic w_cdb_write;

  // Full is decoded from registered count only, so a same-edge commit cannot admit an issue.
  assign w_full       = (r_count == FULL_COUNT);
  assign w_issue      = issueValid && !w_full && readyIn && !r_clear;
  assign w_commit     = readyIn && r_busy[r_head] && r_ready[r_head];
  assign w_mispredict = w_commit && r_is_branch[r_head] &&
                        (r_taken[r_head] != r_pred_taken[r_head]);
  assign w_cdb_write  = cdbValid && r_busy[cdbRobId];

  assign issueRobId     = r_tail;
  assign robFull        = w_full;
  assign regUpdateValid = r_reg_valid;
  assign regUpdateDest  = r_reg_dest;
  assign regUpdateValue = r_reg_value;
  assign regUpdateRobId = r_reg_rob_id;
  assign clearOut       = r_clear;
  assign redirectPcOut  = r_redirect_pc;

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_busy        <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_reg_valid   <= 1'b0;
      r_reg_dest    <= '0;
      r_reg_value   <= '0;
      r_reg_rob_id  <= '0;
      r_clear       <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_reg_valid <= 1'b0;
      r_clear     <= 1'b0;
      if (w_issue) begin
        r_busy[r_tail] <= 1'b1;
        r_tail         <= r_tail + PTR_ONE;
      end
      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + PTR_ONE;
        r_reg_valid    <= (r_dest[r_head] != 5'd0);
        r_reg_dest     <= r_dest[r_head];
        r_reg_value    <= r_value[r_head];
        r_reg_rob_id   <= r_head;
      end
      case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Flush overrides any same-edge issue; the committing link value above still retires.
      if (w_mispredict) begin
        r_busy        <= '0;
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_clear       <= 1'b1;
        r_redirect_pc <= r_redirect[r_head];
      end
    end
  end

  // Payload carries no reset: busy gates every use of it.
  always_ff @(posedge clockIn) begin
    if (w_issue) begin
      r_ready[r_tail]      <= 1'b0;
      r_dest[r_tail]       <= issueDest;
      r_is_branch[r_tail]  <= issueIsBranch;
      r_pred_taken[r_tail] <= issuePredTaken;
      r_redirect[r_tail]   <= issueRedirectPc;
    end
    if (w_cdb_write) begin
      r_ready[cdbRobId] <= 1'b1;
      r_value[cdbRobId] <= cdbValue;
      r_taken[cdbRobId] <= cdbTaken;
    end
  end

  always_comb begin
    robRs1Ready = r_busy[robRs1Dep] && r_ready[robRs1Dep];
    robRs1Value = r_value[robRs1Dep];
    robRs2Ready = r_busy[robRs2Dep] && r_ready[robRs2Dep];
    robRs2Value = r_value[robRs2Dep];
`ifdef ROB_CDB_BYPASS_EN
    if (cdbValid && (cdbRobId == robRs1Dep)) begin
      robRs1Ready = 1'b1;
      robRs1Value = cdbValue;
    end
    if (cdbValid && (cdbRobId == robRs2Dep)) begin
      robRs2Ready = 1'b1;
      robRs2Value = cdbValue;
    end
`endif
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue between the instruction unit, execution units and register file. It allocates one entry per issued instruction and captures results from the common data bus (CDB). It retires the head entry into the register file and answers the register file's operand-dependency lookups. On a branch misprediction at commit it flushes the whole machine and supplies the redirect PC.

## Interface
- ROB_WIDTH, 4, entry-index width; depth = 2^ROB_WIDTH entries (16)
- clockIn  input  1  single clock, all state on rising edge
- resetIn  input  1  asynchronous, active-low reset
- readyIn  input  1  global enable; low freezes issue and commit
- issueValid  input  1  instruction unit presents an instruction
- issueDest  input  5  destination register (0 = no write)
- issueIsBranch  input  1  entry is a conditional branch
- issuePredTaken  input  1  predicted direction
- issueRedirectPc  input  32  PC to fetch if the prediction proves wrong
- issueRobId  output  ROB_WIDTH  tail index the next issued instruction receives
- robFull  output  1  all entries occupied
- cdbValid  input  1  execution result valid
- cdbRobId  input  ROB_WIDTH  entry being completed
- cdbValue  input  32  result value
- cdbTaken  input  1  actual branch direction (ignored for non-branches)
- regUpdateValid  output  1  commit write to register file
- regUpdateDest  output  5  committed destination
- regUpdateValue  output  32  committed value
- regUpdateRobId  output  ROB_WIDTH  committed entry index
- robRs1Dep, robRs2Dep  input  ROB_WIDTH  entry indices queried by the register file
- robRs1Ready, robRs2Ready  output  1  queried entry holds a result
- robRs1Value, robRs2Value  output  32  queried entry's result
- clearOut  output  1  flush pulse to all stages
- redirectPcOut  output  32  fetch target accompanying clearOut

## Operation
- Per-entry state: busy, ready, dest, value, isBranch, predTaken, redirectPc.
- Queue state: head, tail (ROB_WIDTH bits, wrap modulo depth) and count (ROB_WIDTH+1 bits).
- robFull = (count == 2^ROB_WIDTH). It is decoded from registered count only, so a commit in the same cycle does not free a slot for that cycle's issue.
- Issue: issueValid && !robFull && readyIn && !clearOut at the edge.
  - Writes entry[tail] with busy=1, ready=0.
  - tail increments.
- Writeback: cdbValid at the edge with entry[cdbRobId].busy sets ready=1 and stores value and taken. It is independent of readyIn.
  - A CDB write to a non-busy entry is ignored.
- Commit: readyIn && entry[head].busy && entry[head].ready at the edge.
  - Frees the entry and increments head.
  - Registers regUpdate* with valid = (dest != 0).
- Mispredict: a committing branch with taken != predTaken also registers clearOut=1 and redirectPcOut=redirectPc. On the same edge:
  - Every busy bit is cleared.
  - head=tail=count=0.
  - The link value still commits if dest != 0.
- Lookup (combinational): robRsNReady = entry[dep].busy && entry[dep].ready. robRsNValue = entry[dep].value.
- Simultaneous issue and commit: count is unchanged and head and tail both advance.
- Writeback to the head entry: the entry commits on the following edge, never the same edge.

## Timing
- Reset (resetIn low, asynchronous):
  - All busy bits = 0; head = tail = count = 0.
  - regUpdateValid=0, regUpdateDest=0, regUpdateValue=0, regUpdateRobId=0.
  - clearOut=0, redirectPcOut=0, robFull=0, issueRobId=0.
- Reset asserted mid-operation discards all entries immediately. No commit or clear is emitted on release.
- Latency from issue edge to earliest commit edge is 2 cycles (issue, CDB, commit). regUpdate* are valid in the cycle after the commit edge.
- regUpdateValid and clearOut are single-cycle pulses. While clearOut is high, issue is ignored.
- readyIn low: no issue and no commit; regUpdateValid and clearOut drop to 0 next edge; CDB writes still land.

## Configuration
- ROB_CDB_BYPASS_EN defined:
  - The lookup also returns ready=1 and value=cdbValue when cdbValid && cdbRobId == dep in the current cycle.
  - The bypass applies to rs1 and rs2 independently.
  - It saves a cycle for dependents.
- ROB_CDB_BYPASS_EN undefined: lookup reflects registered entry state only.

## Test plan
- Issue 3 instructions (dest x5, x6, x7) and CDB them in order 2, 0, 1 with values 0x22, 0x00, 0x11 -> three commits in order 0, 1, 2 with values 0x00, 0x11, 0x22 on consecutive cycles.
- Issue 16 instructions with no CDB -> robFull=1 and issueRobId=0 after the wrap. A 17th issue is dropped. One commit makes robFull=0 the next cycle.
- Branch at entry 0 with predTaken=0, redirectPc 0x1000, CDB taken=1, and entries 1-3 busy -> clearOut=1 and redirectPcOut=0x1000 for one cycle. Count becomes 0 and a subsequent issueRobId=0.
- Query robRs1Dep=4 while CDB writes entry 4 with value 0xABCD -> ready=1 in the same cycle with ROB_CDB_BYPASS_EN defined, ready=1 one cycle later without it.
- Hold readyIn low for 3 cycles with a ready head and CDB to entry 1 -> no commit while low. Entry 1 is ready after release and both entries commit.
- Drop resetIn low while 5 entries are busy -> all outputs reach their reset values asynchronously, with no regUpdateValid or clearOut pulse.
